// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, byte strobe and framing error.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state, state_nxt;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bad;
    logic             fall;
    logic             cnt_clr, cnt_inc, shift_en, idx_clr, par_chk;
    logic             done_ok, done_ferr, done_perr;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        par_chk   = 1'b0;
        done_ok   = 1'b0;
        done_ferr = 1'b0;
        done_perr = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    if (!rx_s) begin
                        cnt_clr   = 1'b1;
                        idx_clr   = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        // A bad stop bit wins over parity; only a clean frame can flag parity.
                        if (par_bad) done_perr = 1'b1;
                        else         done_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        done_ferr = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (idx_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 1'b1;

            if (shift_en) shreg <= {rx_s, shreg[7:1]};

            // Even parity: the parity bit equals the XOR of the data bits.
            if (idx_clr)      par_bad <= 1'b0;
            else if (par_chk) par_bad <= rx_s ^ (^shreg);

            if (done_ok) data_out <= shreg;
            data_valid <= done_ok;
            frame_err  <= done_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= done_perr;
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit; a queue model tracks expected bytes.
module tb_uart_rx_byte;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] obs_q[$];
    int         t_q[$];
    logic [7:0] exp_q[$];
    int         fcount, pcount, overlap, busy_cyc, cyc;
    logic [7:0] last_good;
    logic       par_flip = 1'b0;

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (data_valid) begin
                obs_q.push_back(data_out);
                t_q.push_back(cyc);
            end
            if (frame_err) fcount++;
            if (data_valid && frame_err) overlap++;
            if (busy) busy_cyc++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pcount++;
`endif
        end
    end

    task automatic clear_mon();
        obs_q.delete(); t_q.delete(); exp_q.delete();
        fcount = 0; pcount = 0; busy_cyc = 0;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`endif
        send_bit(stopv);
        rx = 1'b1;
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic cmp_queue(input string name);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s count got %0d exp %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte[%0d] got %h exp %h", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_out, data_valid, frame_err, busy} !== 11'h0) begin
            errors++;
            $display("FAIL reset_state got do=%h dv=%b fe=%b busy=%b exp 00 0 0 0",
                     data_out, data_valid, frame_err, busy);
        end
        rst = 1'b0;
        idle(4);
        last_good = 8'h00;
    endtask

    task automatic test_single();
        clear_mon();
        send_frame(8'h41, 1'b1); exp_q.push_back(8'h41); last_good = 8'h41;
        idle(8);
        cmp_queue("single_41");
        checks++;
        if (fcount != 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", fcount); end
        // Busy spans half a start bit, eight data bits and one stop bit: 152 clocks.
        checks++;
        if (busy_cyc < 150 || busy_cyc > 154) begin
            errors++; $display("FAIL single_busy_len got %0d exp 150..154", busy_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h30, 1'b1);
        send_frame(8'h39, 1'b1);
        exp_q.push_back(8'h30); exp_q.push_back(8'h39); last_good = 8'h39;
        idle(8);
        cmp_queue("b2b");
        checks++;
        if (t_q.size() != 2 || t_q[1] - t_q[0] != 10 * CPB) begin
            errors++;
            $display("FAIL b2b_spacing got %0d exp %0d", (t_q.size() == 2) ? t_q[1] - t_q[0] : -1, 10 * CPB);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(3 * CPB);
        cmp_queue("glitch");
        checks++;
        if (fcount != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL glitch_state got fe=%0d busy=%b exp 0 0", fcount, busy);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (fcount != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fcount); end
        checks++;
        if (data_out !== last_good) begin
            errors++; $display("FAIL ferr_data_kept got %h exp %h", data_out, last_good);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got %b exp 1", busy); end
        idle(2 * CPB);
        checks++;
        if (busy !== 1'b0 || fcount != 1) begin
            errors++; $display("FAIL ferr_recover got busy=%b fe=%0d exp 0 1", busy, fcount);
        end
        send_frame(8'hC3, 1'b1); exp_q.push_back(8'hC3); last_good = 8'hC3;
        idle(8);
        cmp_queue("ferr_then_good");
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL overlap got %0d exp 0", overlap); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h9A;
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, busy} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid got do=%h dv=%b fe=%b busy=%b exp 00 0 0 0",
                     data_out, data_valid, frame_err, busy);
        end
        @(negedge clk);
        rx = 1'b1; rst = 1'b0; last_good = 8'h00;
        idle(3 * CPB);
        send_frame(8'h46, 1'b1); exp_q.push_back(8'h46); last_good = 8'h46;
        idle(8);
        cmp_queue("after_reset");
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear_mon();
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            exp_q.push_back(b); last_good = b;
            idle($urandom_range(0, 2) * CPB);
        end
        idle(8);
        cmp_queue("random");
        checks++;
        if (data_out !== last_good) begin
            errors++; $display("FAIL random_last got %h exp %h", data_out, last_good);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        par_flip = 1'b0;
        send_frame(8'h41, 1'b1); exp_q.push_back(8'h41); last_good = 8'h41;
        idle(8);
        par_flip = 1'b1;
        send_frame(8'h41, 1'b1);
        send_frame(8'h7E, 1'b1);
        par_flip = 1'b0;
        idle(8);
        cmp_queue("parity");
        checks++;
        if (pcount != 2) begin errors++; $display("FAIL parity_err_count got %0d exp 2", pcount); end
        checks++;
        if (data_out !== last_good) begin
            errors++; $display("FAIL parity_data_kept got %h exp %h", data_out, last_good);
        end
    endtask
`endif

    initial begin
        cyc = 0; overlap = 0;
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver front end for the FPGA UART path. It deserialises an asynchronous 8N1 serial line into bytes and emits each received byte with a one-cycle valid strobe. The ASCII-to-7-segment decoder directly downstream consumes this strobe to latch and display the character. The receiver also flags framing errors and reports a busy status.

Parameters:
CLKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200 baud); legal range 8..65535
CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
data_out  output  8  last correctly received byte
data_valid  output  1  one-cycle pulse; data_out is updated in the same cycle
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst asynchronous, active-high): FSM=IDLE; counters=0; shift register=0; data_out=8'h00; data_valid=0; frame_err=0; busy=0; both synchroniser flops=1.
- rx passes through a 2-flop synchroniser to give rx_s. rx_s is the only version of rx used internally. Edge detection compares rx_s with its previous value.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a falling edge of rx_s, clear the counter and go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division).
  - If rx_s is still 0 at that point: clear the counter, set bit_idx=0, go to DATA.
  - If rx_s is 1: treat as a glitch and return to IDLE with no output.
- DATA: each time the counter reaches CLKS_PER_BIT-1:
  - sample rx_s into the shift register, LSB first;
  - clear the counter and increment bit_idx;
  - after bit_idx 7 is sampled, go to STOP.
- STOP: at counter CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: data_out <= shift register; pulse data_valid for 1 cycle; go to IDLE.
  - rx_s=0: pulse frame_err for 1 cycle; data_out is unchanged; go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 bytes.
- Latency: data_valid asserts 1 cycle after the mid-stop-bit sample. That sample falls 2 sync cycles + 9.5 bit times after the rx falling edge.
- data_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a new start edge is accepted in IDLE immediately after STOP, with no idle bit required beyond the stop bit.
- A falling edge during DATA or STOP is ignored; sampling stays locked to the original start edge.
- rst asserted mid-frame: immediate return to the reset state; the partial byte is discarded.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after data bit 7, handled by an extra PARITY state between DATA and STOP, sampled at counter CLKS_PER_BIT-1.
  - A parity mismatch is latched.
  - At STOP, a good stop bit with a parity mismatch pulses output parity_err (1 bit, reset 0) instead of data_valid, and data_out is not updated.
  - A bad stop bit takes precedence and pulses frame_err only.
  - parity_err exists as a port only when the macro is defined.
- Undefined: 8N1 framing, no PARITY state, no parity_err port.

Test Plan:
- CLKS_PER_BIT=16; send 8N1 byte 0x41 ('A') → exactly one data_valid pulse, data_out=8'h41, frame_err stays 0, busy high for the frame duration.
- Send 0x30 then 0x39 back-to-back with no idle gap → two data_valid pulses 160 cycles apart; data_out=8'h30 then 8'h39.
- Drive rx low for 5 cycles then high (below half a bit) → FSM returns to IDLE; no data_valid, no frame_err.
- Send 0x55 with the stop bit driven 0, then hold rx low for 40 cycles → one frame_err pulse; data_out keeps its previous value; no further pulses until rx returns high and a new frame is received correctly.
- Assert rst during data bit 4 of a frame → all outputs return to reset values the same cycle; the next full frame 0x46 is received correctly.
- With UART_RX_PARITY_EN: send 0x41 with parity bit 0 (correct) → data_valid; send the same byte with parity bit 1 → one parity_err pulse, no data_valid, data_out unchanged.
